mem_wb_skid_stage: RTL and testbench
====================================

// Module: mem_wb_skid_stage
// PURPOSE
// Parametrised MEM->WB pipeline stage with valid/ready handshake and a 2-entry skid buffer.
// Carries the writeback payload: write enable, quarter select, destination register, data.
// Lets MEM keep issuing for one cycle after WB deasserts ready, with no combinational ready path.
// Sits between MEM and WB in place of a fixed single-register latch. Adds flush and occupancy reporting.
// PARAMETERS
// DATA_W  16  width of writeback data
// REG_W   4   width of destination register index
// QTR_W   2   width of quarter-select field
// PORTS
// clk          in   1       clock; all state updates on posedge
// rst_n        in   1       asynchronous, active-low reset
// flush        in   1       synchronous squash of all held entries
// in_valid     in   1       MEM presents a payload
// in_ready     out  1       stage can accept; registered, equals !skid_valid
// in_write     in   1       register-file write enable
// in_quarter   in   QTR_W   quarter select
// in_wreg      in   REG_W   destination register
// in_wdata     in   DATA_W  writeback data
// out_valid    out  1       WB payload valid
// out_ready    in   1       WB consumes payload
// out_write    out  1       write enable; forced 0 when out_valid=0
// out_quarter  out  QTR_W   quarter select of head entry
// out_wreg     out  REG_W   destination register of head entry
// out_wdata    out  DATA_W  data of head entry
// occ          out  2       entries held: 0, 1 or 2
// BEHAVIOUR
// - accept = in_valid & in_ready. pop = out_valid & out_ready.
// - Storage is a main register (drives out_*) and a skid register. Each has a valid bit.
// - FSM on occupancy; occ is the state encoding: EMPTY=0, ONE=1, FULL=2.
//   EMPTY: accept -> ONE, main<=in.
//   ONE: accept&!pop -> FULL, skid<=in. pop&!accept -> EMPTY. accept&pop -> ONE, main<=in.
//   ONE: neither -> hold.
//   FULL: in_ready=0, so no accept. pop -> ONE, main<=skid. else hold.
// - Latency: payload accepted at edge N appears on out_* after edge N (1 cycle) when EMPTY.
// - Ordering is strictly FIFO. The skid entry never overtakes main.
// - While out_valid=1 and out_ready=0, all out_* stay stable.
// - in_ready depends only on state; no combinational path from out_ready.
// - Throughput: 1 entry per cycle sustained when out_ready is held 1.
// - flush=1 at an edge:
//   next state EMPTY, both valid bits cleared;
//   a same-cycle accept is discarded;
//   a same-cycle pop still counts as consumed by WB;
//   payload registers need not be cleared.
// - out_write = main_write & out_valid. A squashed or empty stage never writes the register file.
// - rst_n low, asynchronous and mid-operation:
//   occ=0, out_valid=0, in_ready=1 on the next evaluation;
//   out_write=0, out_quarter=0, out_wreg=0, out_wdata=0.
//   Entries in flight are lost. Release is synchronous to the next posedge.
// - Payload fields are stored as-is; no width conversion or arithmetic.
// TESTING
// 1. Reset, then in_valid=1 with wreg=3, wdata=16'hBEEF, write=1, out_ready=1:
//    out_valid=1, out_wreg=3, out_wdata=BEEF one cycle later; occ=1.
// 2. Stream 8 payloads (wdata 1..8) with out_ready=1:
//    WB sees 1..8 on consecutive cycles, in_ready stays 1.
// 3. out_ready=0 with 2 payloads (A, B) offered:
//    occ=2 and in_ready=0 after 2 cycles, out_wdata=A held.
//    Then out_ready=1: A, then B, occ returns to 0.
// 4. occ=2, assert flush together with in_valid=1:
//    next cycle occ=0, out_valid=0, out_write=0, in_ready=1. The offered payload is never output.
// 5. Drop rst_n mid-stream between clock edges with occ=2:
//    immediately out_valid=0, out_write=0, out_wdata=0, occ=0, with no clock edge needed.
// 6. Random valid/ready toggling for 1000 cycles against a scoreboard:
//    no loss, duplication or reorder; out_* stable whenever stalled.

Source files
------------

// File: rtl/mem_wb_skid_stage.sv
// ---------------------------------------------------------------------------
// mem_wb_skid_stage
//
// MEM->WB pipeline stage with a valid/ready handshake and a two-entry skid
// buffer. MEM may keep issuing for one cycle after WB drops out_ready.
// in_ready comes straight from the state register, so there is no
// combinational path from out_ready back to in_ready.
//
// Ports
//   clk          clock, all state updates on posedge
//   rst_n        asynchronous active-low reset
//   flush        synchronous squash of every held entry
//   in_valid     MEM presents a payload
//   in_ready     stage can accept (registered, low only when both entries full)
//   in_write     register-file write enable
//   in_quarter   quarter select
//   in_wreg      destination register index
//   in_wdata     writeback data
//   out_valid    WB payload valid
//   out_ready    WB consumes the payload
//   out_write    write enable, forced low while out_valid is low
//   out_quarter  quarter select of the head entry
//   out_wreg     destination register of the head entry
//   out_wdata    data of the head entry
//   occ          number of entries held (0, 1 or 2)
// ---------------------------------------------------------------------------
module mem_wb_skid_stage #(
   parameter int DATA_W = 16,
   parameter int REG_W  = 4,
   parameter int QTR_W  = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_write,
   input  logic [QTR_W-1:0]  in_quarter,
   input  logic [REG_W-1:0]  in_wreg,
   input  logic [DATA_W-1:0] in_wdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_write,
   output logic [QTR_W-1:0]  out_quarter,
   output logic [REG_W-1:0]  out_wreg,
   output logic [DATA_W-1:0] out_wdata,
   output logic [1:0]        occ
);

   localparam int PW = 1 + QTR_W + REG_W + DATA_W;

   // The state encoding is the occupancy count, so occ is the state itself.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   main_q, main_d;
   logic [PW-1:0]   skid_q, skid_d;
   logic [PW-1:0]   inPayload;
   logic            mainValid, skidValid;
   logic            accept, pop;

   assign inPayload = {in_write, in_quarter, in_wreg, in_wdata};

   // Valid bits of the two storage registers follow directly from occupancy:
   // main is valid whenever anything is held, skid only when both are used.
   assign mainValid = (state_q != EMPTY);
   assign skidValid = (state_q == FULL);

   assign in_ready  = ~skidValid;
   assign out_valid = mainValid;
   assign accept    = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   assign out_write   = main_q[PW-1] & out_valid;
   assign out_quarter = main_q[DATA_W+REG_W +: QTR_W];
   assign out_wreg    = main_q[DATA_W +: REG_W];
   assign out_wdata   = main_q[DATA_W-1:0];
   assign occ         = state_q;

   // Next-state and payload steering. Main only ever loads from the input
   // when it is (or is becoming) the head with nothing queued behind it, and
   // loads from skid when the head leaves while full, which keeps the order
   // strictly first-in first-out. Flush overrides everything: a same-cycle
   // accept is dropped, and a same-cycle pop has already been taken by WB.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      unique case (state_q)
         EMPTY: begin
            if (accept) begin
               state_d = ONE;
               main_d  = inPayload;
            end
         end
         ONE: begin
            if (accept && !pop) begin
               state_d = FULL;
               skid_d  = inPayload;
            end else if (pop && !accept) begin
               state_d = EMPTY;
            end else if (accept && pop) begin
               main_d  = inPayload;
            end
         end
         FULL: begin
            if (pop) begin
               state_d = ONE;
               main_d  = skid_q;
            end
         end
         default: begin
            state_d = EMPTY;
         end
      endcase
      if (flush) begin
         state_d = EMPTY;
         main_d  = main_q;
         skid_d  = skid_q;
      end
   end

   // State and payload registers. Payload is cleared on reset so the head
   // fields read zero while the stage is held in reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

endmodule

// File: tb/tb_mem_wb_skid_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_wb_skid_stage
//
// Self-checking bench for mem_wb_skid_stage. A queue models the stage
// contents: payloads are pushed when an accept is driven and popped when WB
// takes the head. After every clock the DUT occupancy, handshake and head
// payload are compared against the queue.
// ---------------------------------------------------------------------------
module tb_mem_wb_skid_stage;

   localparam int DATA_W = 16;
   localparam int REG_W  = 4;
   localparam int QTR_W  = 2;
   localparam int PW     = 1 + QTR_W + REG_W + DATA_W;

   logic              clk;
   logic              rst_n;
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic              in_write;
   logic [QTR_W-1:0]  in_quarter;
   logic [REG_W-1:0]  in_wreg;
   logic [DATA_W-1:0] in_wdata;
   logic              out_valid;
   logic              out_ready;
   logic              out_write;
   logic [QTR_W-1:0]  out_quarter;
   logic [REG_W-1:0]  out_wreg;
   logic [DATA_W-1:0] out_wdata;
   logic [1:0]        occ;

   logic [PW-1:0]     sb[$];
   int                total;
   int                bad;

   mem_wb_skid_stage #(
      .DATA_W(DATA_W),
      .REG_W (REG_W),
      .QTR_W (QTR_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_write   (in_write),
      .in_quarter (in_quarter),
      .in_wreg    (in_wreg),
      .in_wdata   (in_wdata),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_write  (out_write),
      .out_quarter(out_quarter),
      .out_wreg   (out_wreg),
      .out_wdata  (out_wdata),
      .occ        (occ)
   );

   // Free-running clock, posedges at 5, 15, 25 ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Compare the DUT against the queue model.
   task automatic verifyModel();
      logic [PW-1:0] head;
      checkOutput("occ", 32'(occ), 32'(sb.size()));
      checkOutput("out_valid", 32'(out_valid), 32'(sb.size() > 0));
      checkOutput("in_ready", 32'(in_ready), 32'(sb.size() < 2));
      if (sb.size() > 0) begin
         head = sb[0];
         checkOutput("out_write", 32'(out_write), 32'(head[PW-1]));
         checkOutput("out_quarter", 32'(out_quarter), 32'(head[DATA_W+REG_W +: QTR_W]));
         checkOutput("out_wreg", 32'(out_wreg), 32'(head[DATA_W +: REG_W]));
         checkOutput("out_wdata", 32'(out_wdata), 32'(head[DATA_W-1:0]));
      end else begin
         checkOutput("out_write_idle", 32'(out_write), 32'd0);
      end
   endtask

   // Called at a negedge: drive one cycle of inputs, update the model for
   // the coming posedge, then wait for the next negedge and check.
   task automatic applyStimulus(input logic v, input logic wr,
                                input logic [QTR_W-1:0] q,
                                input logic [REG_W-1:0] r,
                                input logic [DATA_W-1:0] d,
                                input logic ordy, input logic fl);
      logic acc, pp;
      in_valid   = v;
      in_write   = wr;
      in_quarter = q;
      in_wreg    = r;
      in_wdata   = d;
      out_ready  = ordy;
      flush      = fl;
      acc = v && (sb.size() < 2);
      pp  = ordy && (sb.size() > 0);
      if (pp) void'(sb.pop_front());
      if (fl) sb.delete();
      else if (acc) sb.push_back({wr, q, r, d});
      @(negedge clk);
      verifyModel();
   endtask

   initial begin
      total      = 0;
      bad        = 0;
      rst_n      = 1'b0;
      flush      = 1'b0;
      in_valid   = 1'b0;
      in_write   = 1'b0;
      in_quarter = '0;
      in_wreg    = '0;
      in_wdata   = '0;
      out_ready  = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      verifyModel();
      checkOutput("reset_wdata", 32'(out_wdata), 32'd0);
      checkOutput("reset_wreg", 32'(out_wreg), 32'd0);
      checkOutput("reset_quarter", 32'(out_quarter), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      verifyModel();

      // Single payload, one cycle latency
      $display("[TB] single payload");
      applyStimulus(1'b1, 1'b1, 2'd1, 4'd3, 16'hBEEF, 1'b1, 1'b0);
      checkOutput("t1_wreg", 32'(out_wreg), 32'd3);
      checkOutput("t1_wdata", 32'(out_wdata), 32'hBEEF);
      checkOutput("t1_occ", 32'(occ), 32'd1);
      applyStimulus(1'b0, 1'b0, 2'd0, 4'd0, 16'h0, 1'b1, 1'b0);

      // Back-to-back stream, out_ready held high
      $display("[TB] streaming");
      for (int i = 1; i <= 8; i++) begin
         applyStimulus(1'b1, i[0], i[1:0], i[3:0], 16'(i), 1'b1, 1'b0);
         checkOutput("t2_wdata", 32'(out_wdata), 32'(i));
      end
      applyStimulus(1'b0, 1'b0, 2'd0, 4'd0, 16'h0, 1'b1, 1'b0);

      // Stall with two offered, then drain
      $display("[TB] stall and drain");
      applyStimulus(1'b1, 1'b1, 2'd2, 4'd10, 16'hAAAA, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 2'd3, 4'd11, 16'hBBBB, 1'b0, 1'b0);
      checkOutput("t3_occ", 32'(occ), 32'd2);
      checkOutput("t3_in_ready", 32'(in_ready), 32'd0);
      applyStimulus(1'b1, 1'b1, 2'd0, 4'd12, 16'hCCCC, 1'b0, 1'b0);
      checkOutput("t3_hold", 32'(out_wdata), 32'hAAAA);
      applyStimulus(1'b0, 1'b0, 2'd0, 4'd0, 16'h0, 1'b1, 1'b0);
      checkOutput("t3_second", 32'(out_wdata), 32'hBBBB);
      applyStimulus(1'b0, 1'b0, 2'd0, 4'd0, 16'h0, 1'b1, 1'b0);
      checkOutput("t3_empty", 32'(occ), 32'd0);

      // Flush while full with a payload offered
      $display("[TB] flush");
      applyStimulus(1'b1, 1'b1, 2'd1, 4'd1, 16'h1111, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 2'd1, 4'd2, 16'h2222, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 2'd1, 4'd5, 16'h5555, 1'b0, 1'b1);
      checkOutput("t4_occ", 32'(occ), 32'd0);
      checkOutput("t4_out_write", 32'(out_write), 32'd0);
      for (int i = 0; i < 3; i++)
         applyStimulus(1'b0, 1'b0, 2'd0, 4'd0, 16'h0, 1'b1, 1'b0);

      // Asynchronous reset mid-cycle while full
      $display("[TB] async reset");
      applyStimulus(1'b1, 1'b1, 2'd3, 4'd7, 16'h7777, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 2'd3, 4'd8, 16'h8888, 1'b0, 1'b0);
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      sb.delete();
      checkOutput("t5_occ", 32'(occ), 32'd0);
      checkOutput("t5_out_valid", 32'(out_valid), 32'd0);
      checkOutput("t5_out_write", 32'(out_write), 32'd0);
      checkOutput("t5_out_wdata", 32'(out_wdata), 32'd0);
      checkOutput("t5_out_wreg", 32'(out_wreg), 32'd0);
      checkOutput("t5_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      verifyModel();
      rst_n = 1'b1;
      @(negedge clk);
      verifyModel();

      // Random handshake traffic against the queue model
      $display("[TB] random traffic");
      for (int i = 0; i < 1000; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), 1'($urandom),
                       2'($urandom), 4'($urandom), 16'($urandom),
                       1'($urandom_range(0, 2) != 0),
                       1'($urandom_range(0, 63) == 0));
      end
      for (int i = 0; i < 3; i++)
         applyStimulus(1'b0, 1'b0, 2'd0, 4'd0, 16'h0, 1'b1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
